// File: rtl/seven_seg_capture.sv
// -----------------------------------------------------------------------------
// seven_seg_capture
//
// Receive side of a multiplexed seven-segment display. The block samples the
// active-low segment bus and the active-low anode selects and recovers the
// binary value shown on each digit. It is used as a loopback monitor, so that
// display counter values can be read back as binary.
//
// Optional feature macro: SEVEN_SEG_CAPTURE_HEX_EN
//   When defined, the patterns for A, b, C, d, E and F decode as the legal
//   values 10..15. When undefined, those patterns are illegal.
//
// Ports
//   clk_fpga     in   1             fabric clock, the only clock
//   reset        in   1             synchronous reset, active low
//   seg_in       in   7             segment bus, active low, {g,f,e,d,c,b,a}
//   anode_in     in   NUM_DIGITS    digit selects, active low
//   digits       out  4*NUM_DIGITS  captured value; digit k is [4k+3:4k]
//   digit_valid  out  NUM_DIGITS    slot holds a decode captured within timeout
//   digit_blank  out  NUM_DIGITS    last capture of the slot was all segments off
//   frame_valid  out  1             pulse: every slot captured since last pulse
//   pattern_err  out  1             pulse: an undecodable pattern was captured
// -----------------------------------------------------------------------------
module seven_seg_capture #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clk_fpga,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   anode_in,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    frame_valid,
    output logic                    pattern_err
);

    localparam int         W         = NUM_DIGITS + 7;
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] STAB_SAT  = 8'(STABLE_CYCLES);
    localparam logic [23:0] TO_LOAD  = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Returns {legal, value}.
    function automatic logic [4:0] f_decode(input logic [6:0] i_seg);
        logic [4:0] v_res;
        v_res = 5'b0_0000;
        case (i_seg)
            7'b1000000: v_res = {1'b1, 4'd0};
            7'b1111001: v_res = {1'b1, 4'd1};
            7'b0100100: v_res = {1'b1, 4'd2};
            7'b0110000: v_res = {1'b1, 4'd3};
            7'b0011001: v_res = {1'b1, 4'd4};
            7'b0010010: v_res = {1'b1, 4'd5};
            7'b0000010: v_res = {1'b1, 4'd6};
            7'b1111000: v_res = {1'b1, 4'd7};
            7'b0000000: v_res = {1'b1, 4'd8};
            7'b0010000: v_res = {1'b1, 4'd9};
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
            7'b0001000: v_res = {1'b1, 4'd10};
            7'b0000011: v_res = {1'b1, 4'd11};
            7'b1000110: v_res = {1'b1, 4'd12};
            7'b0100001: v_res = {1'b1, 4'd13};
            7'b0000110: v_res = {1'b1, 4'd14};
            7'b0001110: v_res = {1'b1, 4'd15};
`else
`endif
            default:    v_res = 5'b0_0000;
        endcase
        return v_res;
    endfunction

    logic [W-1:0]                        r_sync1;
    logic [W-1:0]                        r_sync2;
    logic [W-1:0]                        r_prev;
    logic [7:0]                          r_stab_cnt;
    logic                                r_strobe;
    logic [NUM_DIGITS-1:0][23:0]         r_to_cnt;
    logic [NUM_DIGITS-1:0]               r_seen;
    logic [NUM_DIGITS-1:0]               r_valid;
    logic [NUM_DIGITS-1:0]               r_blank;
    logic [4*NUM_DIGITS-1:0]             r_digits;
    logic                                r_frame;
    logic                                r_perr;

    logic [NUM_DIGITS-1:0] w_an_act;
    logic [6:0]            w_seg;
    logic                  w_one_hot;
    logic                  w_qual;
    logic [NUM_DIGITS-1:0] w_cap_mask;
    logic [4:0]            w_dec;
    logic                  w_is_blank;
    logic                  w_legal;
    logic [7:0]            w_stab_next;
    logic                  w_strobe_next;
    logic                  w_frame_full;

    // During the strobe cycle r_prev still holds the value that was stable.
    assign w_an_act   = ~r_prev[W-1:7];
    assign w_seg      = r_prev[6:0];
    assign w_one_hot  = (w_an_act != '0) &&
                        ((w_an_act & (w_an_act - NUM_DIGITS'(1))) == '0);
    assign w_qual     = r_strobe && w_one_hot;
    assign w_cap_mask = w_qual ? w_an_act : '0;
    assign w_dec      = f_decode(w_seg);
    assign w_is_blank = (w_seg == SEG_BLANK);
    assign w_legal    = w_dec[4];
    assign w_frame_full = &r_seen;

    always_comb begin
        w_stab_next = r_stab_cnt;
        if (r_sync2 != r_prev) begin
            w_stab_next = 8'd0;
        end else if (r_stab_cnt != STAB_SAT) begin
            w_stab_next = r_stab_cnt + 8'd1;
        end
    end

    // One strobe per stable period: only on the entry into STABLE_CYCLES-1.
    assign w_strobe_next = (w_stab_next == STAB_LAST) && (r_stab_cnt != STAB_LAST);

    always_ff @(posedge clk_fpga) begin
        if (!reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev     <= '0;
            r_stab_cnt <= '0;
            r_strobe   <= 1'b0;
            r_to_cnt   <= '0;
            r_seen     <= '0;
            r_valid    <= '0;
            r_blank    <= '0;
            r_digits   <= '0;
            r_frame    <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_sync1    <= {anode_in, seg_in};
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_stab_cnt <= w_stab_next;
            r_strobe   <= w_strobe_next;
            r_perr     <= w_qual && !w_legal && !w_is_blank;
            r_frame    <= w_frame_full;
            // A capture coinciding with the frame clear re-marks its slot.
            r_seen     <= (w_frame_full ? '0 : r_seen) | w_cap_mask;

            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (w_cap_mask[k]) begin
                    r_to_cnt[k] <= TO_LOAD;
                    if (w_is_blank) begin
                        r_digits[4*k +: 4] <= 4'd0;
                        r_valid[k]         <= 1'b1;
                        r_blank[k]         <= 1'b1;
                    end else if (w_legal) begin
                        r_digits[4*k +: 4] <= w_dec[3:0];
                        r_valid[k]         <= 1'b1;
                        r_blank[k]         <= 1'b0;
                    end else begin
                        r_valid[k]         <= 1'b0;
                        r_blank[k]         <= 1'b0;
                    end
                end else if (r_to_cnt[k] != 24'd0) begin
                    // Down-counter; expiry clears valid once, then parks at 0.
                    r_to_cnt[k] <= r_to_cnt[k] - 24'd1;
                    if (r_to_cnt[k] == 24'd1) begin
                        r_valid[k] <= 1'b0;
                    end
                end
            end
        end
    end

    assign digits      = r_digits;
    assign digit_valid = r_valid;
    assign digit_blank = r_blank;
    assign frame_valid = r_frame;
    assign pattern_err = r_perr;

endmodule

// File: tb/tb_seven_seg_capture.sv
module tb_seven_seg_capture;

    logic        clk_fpga = 1'b0;
    logic        reset    = 1'b0;
    logic [6:0]  seg_in   = 7'h2A;
    logic [3:0]  anode_in = 4'b0101;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_blank;
    logic        frame_valid;
    logic        pattern_err;

    seven_seg_capture #(
        .NUM_DIGITS     (4),
        .STABLE_CYCLES  (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_fpga    (clk_fpga),
        .reset       (reset),
        .seg_in      (seg_in),
        .anode_in    (anode_in),
        .digits      (digits),
        .digit_valid (digit_valid),
        .digit_blank (digit_blank),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err)
    );

    always #5 clk_fpga = ~clk_fpga;

    int cyc = 0;
    always @(posedge clk_fpga) cyc <= cyc + 1;

`ifdef SEVEN_SEG_CAPTURE_HEX_EN
    localparam logic [3:0] D0 = 4'hA;
`else
    localparam logic [3:0] D0 = 4'h5;
`endif

    typedef struct {
        int          cyc;
        logic [15:0] dig;
        logic [3:0]  val;
        logic [3:0]  blk;
        logic        frm;
        logic        perr;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    task automatic push(input int c, input logic [15:0] d, input logic [3:0] v,
                        input logic [3:0] b, input logic f, input logic p);
        ev_t e;
        e.cyc = c; e.dig = d; e.val = v; e.blk = b; e.frm = f; e.perr = p;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_fpga);
        #1;
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] sg, output int t);
        anode_in = an;
        seg_in   = sg;
        t        = cyc;
    endtask

    // Monitor: any output change or pulse is an event to be matched in order.
    initial begin
        logic [23:0] prev;
        ev_t         e;
        wait (mon_en);
        prev = {digits, digit_valid, digit_blank};
        forever begin
            @(negedge clk_fpga);
            if ({digits, digit_valid, digit_blank} != prev || frame_valid || pattern_err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d dig=%h val=%b blk=%b frm=%b perr=%b",
                             cyc, digits, digit_valid, digit_blank, frame_valid, pattern_err);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.dig != digits || e.val != digit_valid ||
                        e.blk != digit_blank || e.frm != frame_valid || e.perr != pattern_err) begin
                        errors++;
                        $display("FAIL event got cyc=%0d dig=%h val=%b blk=%b frm=%b perr=%b exp cyc=%0d dig=%h val=%b blk=%b frm=%b perr=%b",
                                 cyc, digits, digit_valid, digit_blank, frame_valid, pattern_err,
                                 e.cyc, e.dig, e.val, e.blk, e.frm, e.perr);
                    end
                end
            end
            prev = {digits, digit_valid, digit_blank};
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;

        // Reset with arbitrary inputs.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if ({digits, digit_valid, digit_blank, frame_valid, pattern_err} != '0) begin
                errors++;
                $display("FAIL reset_outputs got dig=%h val=%b blk=%b frm=%b perr=%b exp all zero",
                         digits, digit_valid, digit_blank, frame_valid, pattern_err);
            end
            if (i == 0) begin anode_in = 4'b0010; seg_in = 7'h55; end
            if (i == 1) begin anode_in = 4'b1111; seg_in = 7'b0000000; end
        end
        reset  = 1'b1;
        mon_en = 1'b1;
        tick(100);

        // Single digit: value 3 on slot 0, then timeout.
        drive(4'b1110, 7'b0110000, t);
        push(t + 19, 16'h0003, 4'b0001, 4'b0000, 1'b0, 1'b0);
        push(t + 82, 16'h0003, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(118);

        // Full frame 9,0,4,7.
        drive(4'b1110, 7'b0010000, t);
        push(t + 19, 16'h0009, 4'b0001, 4'b0000, 1'b0, 1'b0);
        tick(20);
        drive(4'b1101, 7'b1000000, t);
        push(t + 19, 16'h0009, 4'b0011, 4'b0000, 1'b0, 1'b0);
        tick(20);
        drive(4'b1011, 7'b0011001, t);
        push(t + 19, 16'h0409, 4'b0111, 4'b0000, 1'b0, 1'b0);
        tick(20);
        drive(4'b0111, 7'b1111000, t);
        push(t + 19, 16'h7409, 4'b1111, 4'b0000, 1'b0, 1'b0);
        push(t + 20, 16'h7409, 4'b1111, 4'b0000, 1'b1, 1'b0);
        push(t + 22, 16'h7409, 4'b1110, 4'b0000, 1'b0, 1'b0);
        push(t + 42, 16'h7409, 4'b1100, 4'b0000, 1'b0, 1'b0);
        push(t + 62, 16'h7409, 4'b1000, 4'b0000, 1'b0, 1'b0);
        push(t + 82, 16'h7409, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(20);
        drive(4'b1111, 7'b0000000, t);
        tick(70);

        // Legal 5 then the 'A' pattern on slot 0.
        drive(4'b1110, 7'b0010010, t);
        push(t + 19, 16'h7405, 4'b0001, 4'b0000, 1'b0, 1'b0);
        tick(20);
        drive(4'b1110, 7'b0001000, t);
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
        push(t + 19, 16'h740A, 4'b0001, 4'b0000, 1'b0, 1'b0);
        push(t + 82, 16'h740A, 4'b0000, 4'b0000, 1'b0, 1'b0);
`else
        push(t + 19, 16'h7405, 4'b0000, 4'b0000, 1'b0, 1'b1);
`endif
        tick(20);
        drive(4'b1111, 7'b0000000, t);
        tick(70);

        // Blank on slot 1, 2 on slot 2, then overwrite slot 1 with 5.
        drive(4'b1101, 7'b1111111, t);
        push(t + 19, {4'h7, 4'h4, 4'h0, D0}, 4'b0010, 4'b0010, 1'b0, 1'b0);
        tick(20);
        drive(4'b1011, 7'b0100100, t);
        push(t + 19, {4'h7, 4'h2, 4'h0, D0}, 4'b0110, 4'b0010, 1'b0, 1'b0);
        tick(20);
        drive(4'b1101, 7'b0010010, t);
        push(t + 19, {4'h7, 4'h2, 4'h5, D0}, 4'b0110, 4'b0000, 1'b0, 1'b0);
        push(t + 62, {4'h7, 4'h2, 4'h5, D0}, 4'b0010, 4'b0000, 1'b0, 1'b0);
        push(t + 82, {4'h7, 4'h2, 4'h5, D0}, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(20);
        drive(4'b1111, 7'b0000000, t);
        tick(70);

        // Segments toggling faster than the stable window, then two anodes low.
        for (int i = 0; i < 6; i++) begin
            drive(4'b1110, (i % 2 == 0) ? 7'b0110000 : 7'b1111001, t);
            tick(8);
        end
        drive(4'b1100, 7'b0110000, t);
        tick(50);

        // Capture slot 0 = 1, then let it time out while anodes are idle.
        drive(4'b1110, 7'b1111001, t);
        push(t + 19, 16'h7251, 4'b0001, 4'b0000, 1'b0, 1'b0);
        push(t + 82, 16'h7251, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(20);
        drive(4'b1111, 7'b0000000, t);
        tick(70);

        // Reset while a sample is pending; capture only after a full period.
        drive(4'b1011, 7'b0000000, t);
        tick(10);
        reset = 1'b0;
        push(t + 11, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(2);
        reset = 1'b1;
        push(t + 31, 16'h0800, 4'b0100, 4'b0000, 1'b0, 1'b0);
        push(t + 94, 16'h0800, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(100);

        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d left exp 0 (next cyc=%0d)",
                     exp_q.size(), exp_q[0].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
